// File: rtl/sadd_pkg.sv
// Shared definitions for the serial signed adder: FSM state encoding and
// helpers deriving and validating the chunk count.
package sadd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  function automatic bit sadd_chunk_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // Guarded so an illegal CHUNK still elaborates far enough to report the error.
  function automatic int sadd_nchunk(input int width, input int chunk);
    return (chunk >= 1) ? (width / chunk) : 1;
  endfunction

endpackage

// File: rtl/sadd_chunk.sv
// CHUNK-bit ripple-carry adder built from 1-bit full adders; also exposes the
// carry into its top bit so the caller can derive signed overflow.
module sadd_chunk #(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] cv;

  // Ripple the carry through one full adder per bit.
  always_comb begin
    cv    = '0;
    s     = '0;
    cv[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]    = a[i] ^ b[i] ^ cv[i];
      cv[i+1] = (a[i] & b[i]) | (cv[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = cv[CHUNK];
  assign c_msb = cv[CHUNK-1];

endmodule

// File: rtl/sadd_serial.sv
// Chunk-serial signed add/subtract with optional saturation: one sadd_chunk
// is reused for NCHUNK cycles, then the result is published with a done pulse.
module sadd_serial
  import sadd_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int NCHUNK = sadd_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (!sadd_chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("sadd_serial: WIDTH must be a positive multiple of CHUNK");
  end

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             sat_q, sat_d, carry_q, carry_d;
  logic             ovf_q, ovf_d, done_q, done_d;

  logic [CHUNK-1:0] ch_a_s, ch_b_s, ch_s_s;
  logic             ch_cout_s, ch_cmsb_s;
  logic [WIDTH-1:0] wrap_s, sat_val_s;
  logic             ovf_s, last_s, accept_s;
  int               base_s;

  assign base_s = int'(idx_q) * CHUNK;
  assign ch_a_s = a_q[base_s +: CHUNK];
  assign ch_b_s = b_q[base_s +: CHUNK];
  assign last_s = (idx_q == LAST_IDX);
  assign accept_s = start && (state_q != RUN);

  sadd_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (ch_a_s),
    .b     (ch_b_s),
    .cin   (carry_q),
    .s     (ch_s_s),
    .cout  (ch_cout_s),
    .c_msb (ch_cmsb_s)
  );

  // Full wrapped result as it will look once the final chunk lands.
  always_comb begin
    wrap_s = acc_q;
    wrap_s[base_s +: CHUNK] = ch_s_s;
  end

  // Overflow can only push toward a's sign, so a's MSB picks the clamp rail.
  assign ovf_s     = ch_cmsb_s ^ ch_cout_s;
  assign sat_val_s = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};

  // State sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;  else state_d = IDLE;
      RUN:  if (last_s) state_d = DONE; else state_d = RUN;
      DONE: if (start) state_d = RUN;  else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, chunk accumulation and result publication.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sat_d   = sat_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (accept_s) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      sat_d   = sat;
      carry_d = sub;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      acc_d[base_s +: CHUNK] = ch_s_s;
      carry_d = ch_cout_s;
      idx_d   = idx_q + IDXW'(1);
      if (last_s) begin
        ovf_d  = ovf_s;
        sum_d  = (sat_q && ovf_s) ? sat_val_s : wrap_s;
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule

// File: doc/sadd_serial.md
SADD_SERIAL -- requirements
Module: sadd_serial

Interface
REQ-001 Parameter WIDTH, default 12: operand and result width in bits, two's-complement signed.
REQ-002 Parameter CHUNK, default 3: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be at least 1.
REQ-003 Derived constant NCHUNK = WIDTH/CHUNK: the cycles per operation.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request an operation; sampled only when busy=0.
REQ-008 sub  input  1  operation select: 0 = a+b, 1 = a-b; captured with start.
REQ-009 sat  input  1  saturate-on-overflow mode; captured with start.
REQ-010 a  input  WIDTH  signed operand A; captured with start.
REQ-011 b  input  WIDTH  signed operand B; captured with start.
REQ-012 busy  output  1  operation in progress.
REQ-013 done  output  1  one-cycle pulse marking a new valid result.
REQ-014 sum  output  WIDTH  signed result.
REQ-015 overflow  output  1  signed-overflow flag for the last result.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE to RUN on start.
- RUN to DONE after NCHUNK RUN cycles.
- DONE to RUN if start is high, else DONE to IDLE.
REQ-017 When start=1 at edge E0 in IDLE or DONE, the block SHALL latch a, b, sub and sat, clear the chunk index to 0, and set the internal carry to sub.
REQ-018 At each edge E1..E_NCHUNK the block SHALL add chunk i of a and chunk i of (b XOR {WIDTH{sub}}) plus the carry, store the CHUNK result bits in the internal accumulator, update the carry, and increment i.
REQ-019 busy SHALL be 1 from after E0 through E_NCHUNK, and 0 in IDLE and DONE.
REQ-020 After E_NCHUNK, done SHALL be 1 for exactly one cycle, and sum and overflow SHALL update in that same cycle.
- Latency from start to done is NCHUNK cycles.
REQ-021 overflow SHALL equal (carry into the MSB) XOR (carry out of the MSB).
REQ-022 Result selection:
- If sat=0, sum SHALL be the WIDTH-bit wrapped result.
- If sat=1 and overflow=1, sum SHALL be 2^(WIDTH-1)-1 when a[WIDTH-1]=0, and -2^(WIDTH-1) when a[WIDTH-1]=1.
REQ-023 The carry out of the MSB SHALL be discarded, with no output port.
REQ-024 sum and overflow SHALL hold their last values until the next done.
- They SHALL NOT change during RUN.
REQ-025 start while busy=1 SHALL be ignored, and operands SHALL NOT be re-latched.
REQ-026 start in the DONE cycle SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-027 Changes on a, b, sub or sat after capture SHALL NOT affect the result in flight.

Reset
REQ-028 While rst=1, the state SHALL be IDLE and busy, done, sum, overflow, the carry, the chunk index and the accumulator SHALL be 0, independent of clk.
REQ-029 Reset during RUN SHALL abort the operation, with no done pulse and no partial result on sum.
REQ-030 After rst falls, the first start SHALL be accepted at the next rising edge.

Structure
REQ-031 A shared package sadd_pkg SHALL hold the state enum (IDLE, RUN, DONE) and a function computing NCHUNK, plus its legality check.
REQ-032 One sub-module, sadd_chunk, SHALL be parametrised by CHUNK and built as a ripple chain of 1-bit full adders.
- Inputs: a, b, cin.
- Outputs: s, cout, and c_msb (the carry into its top bit).
REQ-033 A single sadd_chunk instance SHALL be time-multiplexed across chunks; there SHALL be no WIDTH-wide combinational adder.
REQ-034 Elaboration SHALL fail when WIDTH mod CHUNK is not 0.

Verification (WIDTH=12, CHUNK=3, NCHUNK=4)
REQ-035 a=5, b=7, sub=1, sat=0 -> done 4 cycles after start, sum=12'hFFE (-2), overflow=0.
REQ-036 a=12'h7FF, b=1, sub=0:
- sat=0 -> sum=12'h800, overflow=1.
- repeated with sat=1 -> sum=12'h7FF, overflow=1.
REQ-037 a=12'h800, b=1, sub=1, sat=1 -> sum=12'h800, overflow=1; with sat=0 -> sum=12'h7FF.
REQ-038 Back-to-back: start held high across the DONE cycle with a new operand pair -> two done pulses exactly 5 cycles apart (4 RUN cycles plus the DONE cycle); a second start and new operands applied during RUN of the first -> first result unaffected.
REQ-039 rst pulsed in the 2nd RUN cycle -> busy, done, sum and overflow all 0 immediately; no done pulse follows; the next start completes normally.
REQ-040 Random sweep of 10k operations across all sub/sat combinations -> sum and overflow match a behavioural signed reference model, and every done pulse is exactly 1 cycle wide.
